bit_reversal: RTL and testbench

BIT_REVERSAL -- requirements
Module: bit_reversal

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_bank_ram.sv | 19 +
 rtl/bit_reversal.sv | 75 +++++++
 tb/tb_bit_reversal.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT helpers for index-width derivation and bit reversal.
// Used by bit_reversal and fft_bank_ram; the FFT core reuses it.
package fft_pkg;
  localparam int MAX_LOG2N = 10;
  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction
  // Reverses the low w bits of x. Bits at and above w come back as zero,
  // so callers size-cast the result down to their own index width.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] x, input int w);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LOG2N; i++)
      if (i < w) r[i] = x[4'(w - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_bank_ram.sv
// fft_bank_ram: one N x DW sample bank with a synchronous write port and an asynchronous read port.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module fft_bank_ram import fft_pkg::*; #(
  parameter int N = 16,
  parameter int DW = 32,
  localparam int AW = log2n(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/bit_reversal.sv
// bit_reversal: ping-pong reorder buffer turning natural-order frames into bit-reversed order.
// Ports: clk, rst_n (async active-low); index -> reversed combinational lookup;
// in_valid/in_data/in_ready natural-order input stream;
// out_valid/out_data/out_last/out_ready bit-reversed output stream.
module bit_reversal import fft_pkg::*; #(
  parameter int N = 16,
  parameter int DW = 32,
  localparam int LOG2N = log2n(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LOG2N-1:0] index,
  output logic [LOG2N-1:0] reversed,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic             out_last
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  logic [1:0] full, full_nxt;
  logic wb, rb;
  logic [LOG2N-1:0] wcnt, rcnt, raddr;
  logic [DW-1:0] rdata [2];
  logic in_fire, adv, ld, wlast, rlast;
  assign reversed = LOG2N'(bitrev(MAX_LOG2N'(index), LOG2N));
  assign raddr = LOG2N'(bitrev(MAX_LOG2N'(rcnt), LOG2N));
  assign in_ready = ~full[wb];
  assign in_fire = in_valid & in_ready;
  assign adv = ~out_valid | out_ready;
  assign ld = adv & full[rb];
  assign wlast = wcnt == LAST;
  assign rlast = rcnt == LAST;
  // The writer only touches a non-full bank and the reader only a full one,
  // so the two ports never land on the same bank in one cycle.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_bank_ram #(.N(N), .DW(DW)) u_ram (
      .clk  (clk),
      .we   (in_fire && wb == 1'(g)),
      .waddr(wcnt),
      .wdata(in_data),
      .raddr(raddr),
      .rdata(rdata[g])
    );
  end
  always_comb
    for (int b = 0; b < 2; b++)
      full_nxt[b] = (full[b] | (in_fire & wlast & (wb == 1'(b)))) & ~(ld & rlast & (rb == 1'(b)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        wcnt <= wlast ? '0 : wcnt + 1'b1;
        wb   <= wb ^ wlast;
      end
      if (adv) out_valid <= full[rb];
      if (ld) begin
        out_data <= rdata[rb];
        out_last <= rlast;
        rcnt     <= rlast ? '0 : rcnt + 1'b1;
        rb       <= rb ^ rlast;
      end
    end
endmodule

// File: tb/tb_bit_reversal.sv
// tb_bit_reversal: scoreboard bench for bit_reversal at N=16 plus an N=8 instance.
module tb_bit_reversal;
  localparam int N = 16;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] index, reversed;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic [DW-1:0] in_data = '0, out_data;
  logic [2:0] index8, reversed8;
  logic in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, out_last8;
  logic [DW-1:0] in_data8 = '0, out_data8;
  bit_reversal #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .index(index), .reversed(reversed),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last)
  );
  bit_reversal #(.N(8), .DW(DW)) dut8 (
    .clk(clk), .rst_n(rst_n), .index(index8), .reversed(reversed8),
    .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready8), .out_last(out_last8)
  );
  int passed = 0, failed = 0, total = 0;
  logic [DW:0] q[$], q8[$];
  logic [DW-1:0] fb[16], fb8[8];
  int fcnt = 0, fcnt8 = 0;
  int rev16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int rev8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic done = 1'b0;
  logic held_v = 1'b0;
  logic [DW:0] held = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [DW-1:0] d);
    fb[fcnt] = d;
    fcnt++;
    if (fcnt == N) begin
      for (int k = 0; k < N; k++) q.push_back({k == N - 1, fb[rev16[k]]});
      fcnt = 0;
    end
  endtask

  task automatic accept8(input logic [DW-1:0] d);
    fb8[fcnt8] = d;
    fcnt8++;
    if (fcnt8 == 8) begin
      for (int k = 0; k < 8; k++) q8.push_back({k == 7, fb8[rev8[k]]});
      fcnt8 = 0;
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("in_accept", in_ready, 1);
    if (in_ready) accept(d);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send8(input logic [DW-1:0] d);
    int t = 0;
    in_valid8 = 1'b1;
    in_data8 = d;
    @(negedge clk);
    while (!in_ready8 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("in_accept8", in_ready8, 1);
    if (in_ready8) accept8(d);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_queue", q.size(), 0);
    chk("drain_valid", out_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) held_v = 1'b0;
    else begin
      if (held_v && out_valid) chk("stall_hold", {out_last, out_data}, held);
      if (out_valid && out_ready) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) chk("out16", {out_last, out_data}, q.pop_front());
      end
      held_v = out_valid && !out_ready;
      held = {out_last, out_data};
    end
  end

  always @(negedge clk)
    if (rst_n && out_valid8 && out_ready8) begin
      chk("out8_expected", q8.size() > 0, 1);
      if (q8.size() > 0) chk("out8", {out_last8, out_data8}, q8.pop_front());
    end

  initial begin
    index = '0;
    index8 = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      index = 4'(i);
      #1 chk("rev16", reversed, rev16[i]);
    end
    index8 = 3'd1;
    #1 chk("rev8_1", reversed8, 4);
    index8 = 3'd3;
    #1 chk("rev8_3", reversed8, 6);
    for (int i = 0; i < 8; i++) begin
      index8 = 3'(i);
      #1 chk("rev8", reversed8, rev8[i]);
    end
    // single frame, latency and order
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(DW'(i));
    chk("latency_e", out_valid, 0);
    @(posedge clk);
    #1 chk("latency_e1", out_valid, 1);
    drain();
    // random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send(32'hA000_0000 + DW'(i * 7));
        drain();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    // three frames against a stalled reader
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(32'h5000_0000 + DW'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("both_full_in_ready", in_ready, 0);
    chk("stalled_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 32; i < 48; i++) send(32'h5000_0000 + DW'(i));
    drain();
    // reset mid-frame with a pending frame
    out_ready = 1'b0;
    for (int i = 0; i < 23; i++) send(32'hDEAD_0000 + DW'(i));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_out_data", out_data, 0);
    q.delete();
    fcnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(32'hC0DE_0000 + DW'(i));
    drain();
    // N = 8 frame order
    out_ready8 = 1'b1;
    for (int i = 0; i < 8; i++) send8(DW'(i));
    for (int t = 0; t < 100 && q8.size() > 0; t++) @(posedge clk);
    #1 chk("drain8_queue", q8.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
